mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencer for the memory stage of the RISC-V pipeline. It takes the load/store held in the EX→MEM pipeline register and runs a req/ack transaction on a variable-latency data-memory port. While the transaction is in flight it stalls the upstream pipeline registers and bubbles MEM→WB. It generates byte enables and store lane data, sign/zero-extends load data per funct3, and keeps sticky misalignment and timeout status.

## Interface
- TIMEOUT, 255: maximum number of ACCESS-state cycles to wait for MemAck; range 1..255.
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; returns all state and outputs to reset values immediately.
- MemReadM  in  1  load in MEM stage.
- MemWriteM  in  1  store in MEM stage.
- DextControlM  in  3  funct3 of the MEM-stage instruction (size/sign).
- ALUResultM  in  32  effective byte address.
- WriteDataM  in  32  store data (rs2).
- MemAck  in  1  memory accepted a write or returned read data this cycle.
- MemRData  in  32  read word; valid when MemAck=1.
- ErrClear  in  1  clears ErrStatus on the next edge.
- MemReq  out  1  registered transaction request.
- MemWe  out  1  registered write strobe.
- MemAddr  out  32  registered word address {addr[31:2],2'b00}.
- MemWData  out  32  registered lane-aligned store data.
- MemBe  out  4  registered byte enables.
- StallMem  out  1  holds the PC, IF/ID, ID/EX and EX/MEM registers.
- FlushW  out  1  loads a bubble into MEM/WB; equals StallMem.
- ReadDataM  out  32  extended load result; valid in DONE.
- ErrStatus  out  2  sticky status: bit0 = misaligned, bit1 = timeout.

## Operation
- States:
  - IDLE.
  - ACCESS: MemReq=1, counter running.
  - DONE: one cycle, stall released.
- Access: acc = MemReadM | MemWriteM. If both are high, the access is a store.
- Size is taken from DextControlM:
  - 000 or 100 = byte.
  - 001 or 101 = half.
  - All other codes = word.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
- IDLE, acc and aligned:
  - StallMem=1 (combinational).
  - Next edge → ACCESS.
  - Load MemReq=1, MemWe=store, MemAddr, MemBe, MemWData.
  - Latch addr[1:0] and funct3.
  - Clear the counter.
- IDLE, acc and misaligned:
  - No request, no stall, instruction proceeds.
  - ErrStatus[0] set next edge.
  - ReadDataM=0.
- ACCESS:
  - StallMem=1; request outputs stable.
  - MemAck=1 → capture MemRData (loads), clear MemReq and MemWe, → DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without an ack → clear MemReq, captured word=0, set ErrStatus[1], → DONE.
- DONE:
  - StallMem=0; the pipeline advances with ReadDataM valid.
  - Next edge → IDLE unconditionally. The held instruction is never re-issued.
- Byte enables:
  - byte: MemBe=4'b0001<<addr[1:0].
  - half: 4'b0011<<{addr[1],1'b0}.
  - word: 4'b1111.
- Store data:
  - byte: WriteDataM[7:0] replicated ×4.
  - half: [15:0] replicated ×2.
  - word: unchanged.
- Load data: lane selected by the latched addr[1:0] from the captured word.
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW unchanged.
  - ReadDataM=0 outside DONE.
- MemAck outside ACCESS is ignored.
- ErrClear and a simultaneous set: the set wins.

## Timing
- Reset values:
  - State=IDLE, MemReq=0, MemWe=0, MemAddr=0, MemWData=0, MemBe=0.
  - Counter=0, captured word=0, ErrStatus=0.
  - StallMem=FlushW=0 (combinational from IDLE with no access).
- Aligned access with ack on the first ACCESS cycle:
  - StallMem high for 2 cycles (IDLE detect, ACCESS).
  - DONE on the 3rd cycle, so the instruction occupies MEM for 3 cycles.
- Each additional ack wait adds 1 cycle.
- Timeout: DONE follows exactly TIMEOUT ACCESS cycles.
- Back-to-back accesses: DONE → IDLE → the next access is detected in IDLE. A minimum of 1 non-stall cycle (DONE) separates transactions.
- Reset asserted mid-ACCESS: MemReq drops without waiting for an edge. A later ack is ignored.
- Non-memory instructions: zero added latency; StallMem stays 0.

## Test plan
- LW, addr 0x100, ack on the first ACCESS cycle, MemRData=0xDEADBEEF:
  - MemBe=1111, MemAddr=0x100.
  - StallMem high for 2 cycles.
  - ReadDataM=0xDEADBEEF in DONE.
- LB, addr 0x103, ack after 3 wait cycles, MemRData=0x80112233 → MemBe=1000, stall lasts 5 cycles, ReadDataM=0xFFFFFF80. LBU with the same data → 0x00000080.
- SH, addr 0x202, WriteDataM=0x0000ABCD:
  - MemWe=1, MemBe=1100, MemWData=0xABCDABCD.
  - After ack, MemReq=0 and DONE is reached.
- LW at 0x101 → no MemReq, StallMem=0, ErrStatus=01. An ErrClear pulse then returns ErrStatus=00.
- TIMEOUT=4, load with no ack:
  - MemReq high for 4 cycles, then DONE.
  - ReadDataM=0, ErrStatus[1]=1.
  - A late ack in IDLE has no effect.
- Reset asserted 2 cycles into ACCESS: MemReq and StallMem drop asynchronously, state=IDLE, and all outputs are at their reset values.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer for a variable-latency
// data-memory port, with lane steering, load extension and sticky status.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  DextControlM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  input  logic        ErrClear,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemBe,
  output logic        StallMem,
  output logic        FlushW,
  output logic [31:0] ReadDataM,
  output logic [1:0]  ErrStatus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] word;
  logic [1:0]  lat_a;
  logic [2:0]  lat_f3;

  logic        acc, is_byte, is_half, mis;
  logic        start, mis_set, to_set;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [7:0]  b8;
  logic [15:0] h16;

  always_comb begin
    acc     = MemReadM | MemWriteM;
    is_byte = DextControlM[1:0] == 2'b00;
    is_half = DextControlM[1:0] == 2'b01;
    mis     = (is_half & ALUResultM[0]) |
              (~is_byte & ~is_half & (ALUResultM[1:0] != 2'b00));
    start   = (state == IDLE) & acc & ~mis;
    mis_set = (state == IDLE) & acc & mis;
    to_set  = (state == ACCESS) & ~MemAck & (cnt == CNT_LAST);
  end

  always_comb begin
    be_n = 4'b1111;
    wd_n = WriteDataM;
    unique case (1'b1)
      is_byte: begin
        be_n = 4'b0001 << ALUResultM[1:0];
        wd_n = {4{WriteDataM[7:0]}};
      end
      is_half: begin
        be_n = 4'b0011 << {ALUResultM[1], 1'b0};
        wd_n = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  // Reset gates the stall so the pipeline is released as soon as reset rises.
  assign StallMem = ~reset & (start | (state == ACCESS));
  assign FlushW   = StallMem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      MemReq    <= 1'b0;
      MemWe     <= 1'b0;
      MemAddr   <= '0;
      MemWData  <= '0;
      MemBe     <= '0;
      cnt       <= '0;
      word      <= '0;
      lat_a     <= '0;
      lat_f3    <= '0;
      ErrStatus <= '0;
    end else begin
      ErrStatus <= (ErrClear ? 2'b00 : ErrStatus) | {to_set, mis_set};
      unique case (state)
        IDLE: if (start) begin
          state    <= ACCESS;
          MemReq   <= 1'b1;
          MemWe    <= MemWriteM;
          MemAddr  <= {ALUResultM[31:2], 2'b00};
          MemBe    <= be_n;
          MemWData <= wd_n;
          lat_a    <= ALUResultM[1:0];
          lat_f3   <= DextControlM;
          cnt      <= '0;
        end
        ACCESS: begin
          if (MemAck) begin
            if (!MemWe) word <= MemRData;
            MemReq <= 1'b0;
            MemWe  <= 1'b0;
            state  <= DONE;
          end else if (cnt == CNT_LAST) begin
            word   <= '0;
            MemReq <= 1'b0;
            MemWe  <= 1'b0;
            state  <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    unique case (lat_a)
      2'd0: b8 = word[7:0];
      2'd1: b8 = word[15:8];
      2'd2: b8 = word[23:16];
      default: b8 = word[31:24];
    endcase
    h16 = lat_a[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    ReadDataM = '0;
    if (state == DONE) begin
      unique case (1'b1)
        lat_f3[1:0] == 2'b00:
          ReadDataM = {{24{b8[7] & ~lat_f3[2]}}, b8};
        lat_f3[1:0] == 2'b01:
          ReadDataM = {{16{h16[15] & ~lat_f3[2]}}, h16};
        default:
          ReadDataM = word;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for the MEM-stage sequencer,
// built with a short timeout to reach the timeout path quickly.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  DextControlM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        MemAck;
  logic [31:0] MemRData;
  logic        ErrClear;
  logic        MemReq, MemWe;
  logic [31:0] MemAddr, MemWData;
  logic [3:0]  MemBe;
  logic        StallMem, FlushW;
  logic [31:0] ReadDataM;
  logic [1:0]  ErrStatus;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic [31:0] rdata;
    logic        chk_rd;
    int          stall;
  } exp_t;

  exp_t q[$];

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .DextControlM(DextControlM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .MemAck(MemAck),
    .MemRData(MemRData), .ErrClear(ErrClear),
    .MemReq(MemReq), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemWData(MemWData),
    .MemBe(MemBe), .StallMem(StallMem),
    .FlushW(FlushW), .ReadDataM(ReadDataM),
    .ErrStatus(ErrStatus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(
    input logic wr, input logic [2:0] f3,
    input logic [31:0] a, wd, rdat, input int waits
  );
    exp_t e;
    logic [7:0]  b;
    logic [15:0] h;
    e.addr   = {a[31:2], 2'b00};
    e.we     = wr;
    e.chk_rd = !wr;
    e.stall  = 1 + ((waits < TO) ? waits + 1 : TO);
    b = rdat[8*a[1:0] +: 8];
    h = a[1] ? rdat[31:16] : rdat[15:0];
    case (f3)
      3'b000: begin e.be = 4'b0001 << a[1:0]; e.wdata = {4{wd[7:0]}};
                    e.rdata = {{24{b[7]}}, b}; end
      3'b100: begin e.be = 4'b0001 << a[1:0]; e.wdata = {4{wd[7:0]}};
                    e.rdata = {24'h0, b}; end
      3'b001: begin e.be = a[1] ? 4'b1100 : 4'b0011; e.wdata = {2{wd[15:0]}};
                    e.rdata = {{16{h[15]}}, h}; end
      3'b101: begin e.be = a[1] ? 4'b1100 : 4'b0011; e.wdata = {2{wd[15:0]}};
                    e.rdata = {16'h0, h}; end
      default: begin e.be = 4'b1111; e.wdata = wd; e.rdata = rdat; end
    endcase
    if (waits >= TO) e.rdata = 32'h0;
    return e;
  endfunction

  // Starts at a negedge with the DUT idle; ends at a negedge back in IDLE.
  task automatic run_txn(
    input string nm, input logic rd, wr, input logic [2:0] f3,
    input logic [31:0] a, wd, rdat, input int waits
  );
    exp_t e;
    int   stall;
    bit   done;
    q.push_back(model(wr, f3, a, wd, rdat, waits));
    MemReadM = rd; MemWriteM = wr; DextControlM = f3;
    ALUResultM = a; WriteDataM = wd; MemRData = rdat;
    #1;
    stall = StallMem ? 1 : 0;
    done  = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (StallMem) begin
        stall++;
        checks++;
        if (MemReq !== 1'b1) begin
          errors++; $display("FAIL %s req act=%b req=1 cyc=%0d", nm, MemReq, i);
        end
        if (i == 0) begin
          checks++;
          if ({MemAddr, MemWData, MemBe, MemWe} !==
              {q[0].addr, q[0].wdata, q[0].be, q[0].we}) begin
            errors++;
            $display("FAIL %s reqfields act=%h/%h/%b/%b req=%h/%h/%b/%b",
              nm, MemAddr, MemWData, MemBe, MemWe,
              q[0].addr, q[0].wdata, q[0].be, q[0].we);
          end
        end
        MemAck = (i == waits);
      end else begin
        MemAck = 1'b0;
        e = q.pop_front();
        done = 1;
        if (e.chk_rd) begin
          checks++;
          if (ReadDataM !== e.rdata) begin
            errors++; $display("FAIL %s rdata act=%h req=%h", nm, ReadDataM, e.rdata);
          end
        end
        checks++;
        if (MemReq !== 1'b0 || FlushW !== 1'b0) begin
          errors++; $display("FAIL %s done_req act=%b/%b req=0/0", nm, MemReq, FlushW);
        end
        checks++;
        if (stall != e.stall) begin
          errors++; $display("FAIL %s stall act=%0d req=%0d", nm, stall, e.stall);
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s no_done act=stuck req=DONE", nm);
      void'(q.pop_front());
    end
    MemReadM = 0; MemWriteM = 0; MemAck = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1;
    MemReadM = 0; MemWriteM = 0; DextControlM = 0; ALUResultM = 0;
    WriteDataM = 0; MemAck = 0; MemRData = 0; ErrClear = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({MemReq, MemWe, MemAddr, MemWData, MemBe, StallMem, FlushW,
         ReadDataM, ErrStatus} !== '0) begin
      errors++; $display("FAIL reset_state act=%b%b %h %h %b %b%b %h %b req=0",
        MemReq, MemWe, MemAddr, MemWData, MemBe, StallMem, FlushW,
        ReadDataM, ErrStatus);
    end
    reset = 0;
    @(negedge clk);
    checks++;
    if (StallMem !== 1'b0) begin
      errors++; $display("FAIL nomem_stall act=%b req=0", StallMem);
    end
  endtask

  task automatic test_loads();
    run_txn("lw",  1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0);
    run_txn("lb",  1, 0, 3'b000, 32'h103, 0, 32'h80112233, 3);
    run_txn("lbu", 1, 0, 3'b100, 32'h103, 0, 32'h80112233, 3);
    run_txn("lh",  1, 0, 3'b001, 32'h042, 0, 32'h9ABC1234, 1);
    run_txn("lhu", 1, 0, 3'b101, 32'h040, 0, 32'h1234F00D, 2);
  endtask

  task automatic test_store();
    run_txn("sh", 0, 1, 3'b001, 32'h202, 32'h0000ABCD, 0, 1);
    run_txn("sb", 0, 1, 3'b000, 32'h301, 32'h000000A5, 0, 0);
    run_txn("rw", 1, 1, 3'b010, 32'h400, 32'h12345678, 0, 0);
  endtask

  task automatic test_misaligned();
    MemReadM = 1; DextControlM = 3'b010; ALUResultM = 32'h101;
    #1;
    checks++;
    if (StallMem !== 1'b0) begin
      errors++; $display("FAIL mis_stall act=%b req=0", StallMem);
    end
    @(negedge clk);
    MemReadM = 0;
    checks++;
    if ({MemReq, ErrStatus, ReadDataM} !== {1'b0, 2'b01, 32'h0}) begin
      errors++; $display("FAIL mis_status act=%b/%b/%h req=0/01/0",
        MemReq, ErrStatus, ReadDataM);
    end
    ErrClear = 1;
    @(negedge clk);
    ErrClear = 0;
    checks++;
    if (ErrStatus !== 2'b00) begin
      errors++; $display("FAIL errclear act=%b req=00", ErrStatus);
    end
  endtask

  task automatic test_timeout();
    run_txn("timeout", 1, 0, 3'b010, 32'h500, 0, 32'hCAFEF00D, 99);
    checks++;
    if (ErrStatus !== 2'b10) begin
      errors++; $display("FAIL to_status act=%b req=10", ErrStatus);
    end
    MemAck = 1;
    @(negedge clk);
    MemAck = 0;
    checks++;
    if ({MemReq, StallMem, ReadDataM} !== {2'b00, 32'h0}) begin
      errors++; $display("FAIL late_ack act=%b%b %h req=00 0",
        MemReq, StallMem, ReadDataM);
    end
  endtask

  task automatic test_back_to_back();
    run_txn("b2b0", 1, 0, 3'b010, 32'h600, 0, 32'h11111111, 0);
    run_txn("b2b1", 1, 0, 3'b000, 32'h604, 0, 32'h0000007F, 0);
  endtask

  task automatic test_reset_mid();
    MemReadM = 1; DextControlM = 3'b010; ALUResultM = 32'h700;
    repeat (3) @(negedge clk);
    checks++;
    if ({MemReq, StallMem} !== 2'b11) begin
      errors++; $display("FAIL pre_rst act=%b%b req=11", MemReq, StallMem);
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({MemReq, MemWe, MemAddr, MemWData, MemBe, StallMem, FlushW,
         ReadDataM, ErrStatus} !== '0) begin
      errors++; $display("FAIL async_rst act=%b%b %h %h %b %b%b %h %b req=0",
        MemReq, MemWe, MemAddr, MemWData, MemBe, StallMem, FlushW,
        ReadDataM, ErrStatus);
    end
    MemReadM = 0;
    @(negedge clk);
    reset = 0;
    MemAck = 1;
    @(negedge clk);
    MemAck = 0;
    checks++;
    if ({MemReq, StallMem, ReadDataM} !== {2'b00, 32'h0}) begin
      errors++; $display("FAIL post_rst_ack act=%b%b %h req=00 0",
        MemReq, StallMem, ReadDataM);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1);
  end

endmodule
